// File: rtl/binary_div_seq.sv
// Sequential unsigned restoring divider: one trial subtraction per clock,
// start/done handshake, divide-by-zero flagged with Quo=all ones, Rem=Dividend.
module binary_div_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] Dividend,
  input  logic [N-1:0] Divisor,
  output logic [N-1:0] Quo,
  output logic [N-1:0] Rem,
  output logic         busy,
  output logic         done,
  output logic         DivZero
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_q;
  logic [N-1:0]  r_d;
  logic [N:0]    r_r;
  logic [CW-1:0] r_cnt;

  logic [N:0]    w_r_shift;
  logic [N:0]    w_trial;
  logic          w_fits;
  logic [N:0]    w_r_next;
  logic [N-1:0]  w_q_next;
  logic          w_last;

  // One restoring step: shift next dividend bit into R, keep the difference only if it fits.
  assign w_r_shift = {r_r[N-1:0], r_q[N-1]};
  assign w_trial   = w_r_shift - {1'b0, r_d};
  assign w_fits    = ~w_trial[N];
  assign w_r_next  = w_fits ? w_trial : w_r_shift;
  assign w_q_next  = {r_q[N-2:0], w_fits};
  assign w_last    = (r_cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_d     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      Quo     <= '0;
      Rem     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            r_q   <= Dividend;
            r_d   <= Divisor;
            r_r   <= '0;
            r_cnt <= '0;
            if (Divisor == '0) begin
              Quo     <= '1;
              Rem     <= Dividend;
              DivZero <= 1'b1;
              done    <= 1'b1;
              r_state <= DONE;
            end else begin
              busy    <= 1'b1;
              r_state <= CALC;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_r   <= w_r_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            Quo     <= w_q_next;
            Rem     <= w_r_next[N-1:0];
            DivZero <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
